// File: rtl/seg7_value_display.sv
// Sequential binary-to-7-segment driver: double-dabble decimal or raw hex,
// with leading-zero blanking and overflow dashes.
//
// Ports:
//   iCLK, iRST_n        clock, async active-low reset
//   iValue, iLoad       value and load request (accepted when oBusy=0)
//   iHexMode, iBlankLZ  display mode and leading-zero blanking, sampled on load
//   oBusy               conversion in progress, iLoad ignored
//   oDone               one-cycle pulse when oSeg/oOverflow are updated
//   oOverflow           last value did not fit in DIGITS digits
//   oSeg                active-low segments, digit i on oSeg[8i+7:8i], DP off
module seg7_value_display #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 6
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    input  logic [BIN_W-1:0]      iValue,
    input  logic                  iLoad,
    input  logic                  iHexMode,
    input  logic                  iBlankLZ,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oOverflow,
    output logic [8*DIGITS-1:0]   oSeg
);

    // Enough BCD digits to hold any BIN_W-bit value without loss.
    localparam int BCD_N     = (BIN_W + 2) / 3 + 1;
    localparam int BCD_W     = 4 * BCD_N;
    localparam int CNT_W     = $clog2(BIN_W + 1);
    // Zero-extended views so missing digits/nibbles read as 0.
    localparam int HEX_EXT_W = BIN_W + 4 * DIGITS;
    localparam int BCD_EXT_W = BCD_W + 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [BIN_W-1:0]      bin_q, bin_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  hex_q, hex_d;
    logic                  blank_q, blank_d;
    logic [8*DIGITS-1:0]   seg_q, seg_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    logic [BCD_W-1:0]      bcd_adj;
    logic [HEX_EXT_W-1:0]  hex_ext;
    logic [BCD_EXT_W-1:0]  bcd_ext;
    logic [3:0]            nib [DIGITS];
    logic                  disp_ovf;
    logic [8*DIGITS-1:0]   disp_seg;
    logic                  lead;

    function automatic logic [7:0] seg_code(input logic [3:0] n);
        logic [7:0] c;
        c = 8'hFF;
        case (n)
            4'h0: c = 8'hC0;
            4'h1: c = 8'hF9;
            4'h2: c = 8'hA4;
            4'h3: c = 8'hB0;
            4'h4: c = 8'h99;
            4'h5: c = 8'h92;
            4'h6: c = 8'h82;
            4'h7: c = 8'hF8;
            4'h8: c = 8'h80;
            4'h9: c = 8'h90;
            4'hA: c = 8'h88;
            4'hB: c = 8'h83;
            4'hC: c = 8'hC6;
            4'hD: c = 8'hA1;
            4'hE: c = 8'h86;
            4'hF: c = 8'h8E;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    // Double-dabble correction: bump every BCD digit >= 5 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Display image computed from the finished conversion.
    always_comb begin
        hex_ext  = HEX_EXT_W'(bin_q);
        bcd_ext  = BCD_EXT_W'(bcd_q);
        disp_seg = '1;
        lead     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib[i] = hex_q ? hex_ext[4*i +: 4] : bcd_ext[4*i +: 4];
        end
        disp_ovf = hex_q ? |hex_ext[HEX_EXT_W-1:4*DIGITS]
                         : |bcd_ext[BCD_EXT_W-1:4*DIGITS];
        // Walk from the top digit down; blank while still in leading zeros.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (nib[i] != 4'd0) begin
                lead = 1'b0;
            end
            if (disp_ovf) begin
                disp_seg[8*i +: 8] = 8'hBF;
            end else if (blank_q && lead && (i != 0)) begin
                disp_seg[8*i +: 8] = 8'hFF;
            end else begin
                disp_seg[8*i +: 8] = seg_code(nib[i]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        blank_d = blank_q;
        seg_d   = seg_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iLoad) begin
                    bin_d   = iValue;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    hex_d   = iHexMode;
                    blank_d = iBlankLZ;
                    state_d = iHexMode ? S_LATCH : S_SHIFT;
                end
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                seg_d   = disp_seg;
                ovf_d   = disp_ovf;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hex_q   <= 1'b0;
            blank_q <= 1'b0;
            seg_q   <= '1;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            blank_q <= blank_d;
            seg_q   <= seg_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign oBusy     = (state_q != S_IDLE);
    assign oDone     = done_q;
    assign oOverflow = ovf_q;
    assign oSeg      = seg_q;

endmodule

// File: tb/tb_seg7_value_display.sv
// Directed and randomized checks of seg7_value_display (BIN_W=32, DIGITS=6)
// against an arithmetic reference model.
module tb_seg7_value_display;

    logic        iCLK;
    logic        iRST_n;
    logic [31:0] iValue;
    logic        iLoad;
    logic        iHexMode;
    logic        iBlankLZ;
    logic        oBusy;
    logic        oDone;
    logic        oOverflow;
    logic [47:0] oSeg;

    int vecs;
    int miss;

    localparam logic [7:0] CODES [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg7_value_display #(.BIN_W(32), .DIGITS(6)) dut (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .iValue    (iValue),
        .iLoad     (iLoad),
        .iHexMode  (iHexMode),
        .iBlankLZ  (iBlankLZ),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oOverflow (oOverflow),
        .oSeg      (oSeg)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: digits by division/shift, overflow by magnitude.
    function automatic logic [47:0] ref_seg(input logic [31:0] v,
                                            input bit hex,
                                            input bit blank,
                                            output bit ovf);
        logic [47:0]     r;
        int              d [6];
        int              msd;
        longint unsigned x;
        longint unsigned p;
        x   = 64'(v);
        p   = 1;
        msd = 0;
        ovf = hex ? (v >= 32'h0100_0000) : (x >= 64'd1000000);
        for (int i = 0; i < 6; i++) begin
            if (hex) d[i] = int'((x >> (4 * i)) & 64'd15);
            else begin
                d[i] = int'((x / p) % 64'd10);
                p = p * 10;
            end
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < 6; i++) begin
            if (ovf) r[8*i +: 8] = 8'hBF;
            else if (blank && i > msd) r[8*i +: 8] = 8'hFF;
            else r[8*i +: 8] = CODES[d[i]];
        end
        return r;
    endfunction

    // Drive a load across edge E0; immediate=1 drives without waiting
    // for a falling edge (used in the oDone cycle).
    task automatic start_load(input logic [31:0] v, input bit hex,
                              input bit blank, input bit immediate);
        if (!immediate) @(negedge iCLK);
        iValue   = v;
        iHexMode = hex;
        iBlankLZ = blank;
        iLoad    = 1'b1;
        @(posedge iCLK);
        #1 iLoad = 1'b0;
    endtask

    // Count edges after E0 until oDone; oBusy must stay high until then.
    // A nonzero pulse_at injects an iLoad of pulse_v across that edge.
    task automatic wait_done(input string tag, input int exp_lat,
                             input int pulse_at, input logic [31:0] pulse_v);
        int n;
        bit busy_bad;
        bit got;
        busy_bad = 1'b0;
        got      = 1'b0;
        n        = 0;
        for (int k = 1; k <= 100 && !got; k++) begin
            if (k == pulse_at) begin
                iValue = pulse_v;
                iLoad  = 1'b1;
            end
            @(posedge iCLK);
            #1;
            if (k == pulse_at) iLoad = 1'b0;
            n = k;
            if (oDone) got = 1'b1;
            else if (!oBusy) busy_bad = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_busy_span"}, 64'(busy_bad), 64'd0);
    endtask

    task automatic run_case(input string tag, input logic [31:0] v,
                            input bit hex, input bit blank);
        logic [47:0] es;
        bit          eo;
        es = ref_seg(v, hex, blank, eo);
        start_load(v, hex, blank, 1'b0);
        wait_done(tag, hex ? 1 : 33, 0, 32'd0);
        check({tag, "_seg"}, 64'(oSeg), 64'(es));
        check({tag, "_ovf"}, 64'(oOverflow), 64'(eo));
    endtask

    initial begin
        bit          bad;
        logic [31:0] rv;
        bit          rh;
        bit          rb;
        vecs     = 0;
        miss     = 0;
        iRST_n   = 1'b0;
        iValue   = '0;
        iLoad    = 1'b0;
        iHexMode = 1'b0;
        iBlankLZ = 1'b0;
        #12;
        check("rst_seg", 64'(oSeg), 64'hFFFF_FFFF_FFFF);
        check("rst_busy", 64'(oBusy), 64'd0);
        check("rst_done", 64'(oDone), 64'd0);
        check("rst_ovf", 64'(oOverflow), 64'd0);
        @(negedge iCLK);
        iRST_n = 1'b1;

        // 1: decimal 1234 with blanking; done must be a single-cycle pulse
        start_load(32'd1234, 1'b0, 1'b1, 1'b0);
        wait_done("dec1234", 33, 0, 32'd0);
        check("dec1234_seg", 64'(oSeg), 64'hFFFF_F9A4_B099);
        check("dec1234_ovf", 64'(oOverflow), 64'd0);
        @(posedge iCLK);
        #1 check("dec1234_done_pulse", 64'(oDone), 64'd0);

        // 2: zero with and without blanking
        start_load(32'd0, 1'b0, 1'b1, 1'b0);
        wait_done("zero_blank", 33, 0, 32'd0);
        check("zero_blank_seg", 64'(oSeg), 64'hFFFF_FFFF_FFC0);
        start_load(32'd0, 1'b0, 1'b0, 1'b0);
        wait_done("zero_noblank", 33, 0, 32'd0);
        check("zero_noblank_seg", 64'(oSeg), 64'hC0C0_C0C0_C0C0);

        // 3: decimal boundaries
        start_load(32'd999999, 1'b0, 1'b1, 1'b0);
        wait_done("dec999999", 33, 0, 32'd0);
        check("dec999999_seg", 64'(oSeg), 64'h9090_9090_9090);
        check("dec999999_ovf", 64'(oOverflow), 64'd0);
        start_load(32'd1000000, 1'b0, 1'b1, 1'b0);
        wait_done("dec1e6", 33, 0, 32'd0);
        check("dec1e6_seg", 64'(oSeg), 64'hBFBF_BFBF_BFBF);
        check("dec1e6_ovf", 64'(oOverflow), 64'd1);
        start_load(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        wait_done("decmax", 33, 0, 32'd0);
        check("decmax_seg", 64'(oSeg), 64'hBFBF_BFBF_BFBF);
        check("decmax_ovf", 64'(oOverflow), 64'd1);

        // 4: hex mode and hex overflow
        start_load(32'h00AB_CDEF, 1'b1, 1'b1, 1'b0);
        wait_done("hexabcdef", 1, 0, 32'd0);
        check("hexabcdef_seg", 64'(oSeg), 64'h8883_C6A1_868E);
        check("hexabcdef_ovf", 64'(oOverflow), 64'd0);
        start_load(32'h0100_0000, 1'b1, 1'b1, 1'b0);
        wait_done("hexovf", 1, 0, 32'd0);
        check("hexovf_seg", 64'(oSeg), 64'hBFBF_BFBF_BFBF);
        check("hexovf_ovf", 64'(oOverflow), 64'd1);

        // 5: load while busy dropped; load in done cycle accepted
        start_load(32'd42, 1'b0, 1'b1, 1'b0);
        wait_done("busy42", 33, 5, 32'd77);
        check("busy42_seg", 64'(oSeg), 64'hFFFF_FFFF_99A4);
        start_load(32'd77, 1'b0, 1'b1, 1'b1);
        wait_done("back77", 33, 0, 32'd0);
        check("back77_seg", 64'(oSeg), 64'hFFFF_FFFF_F8F8);

        // 6: reset in the middle of a conversion
        start_load(32'd123456, 1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge iCLK);
        #1 iRST_n = 1'b0;
        #1;
        check("midrst_seg", 64'(oSeg), 64'hFFFF_FFFF_FFFF);
        check("midrst_busy", 64'(oBusy), 64'd0);
        check("midrst_ovf", 64'(oOverflow), 64'd0);
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge iCLK);
            #1 if (oDone) bad = 1'b1;
        end
        check("midrst_no_done", 64'(bad), 64'd0);
        @(negedge iCLK);
        iRST_n = 1'b1;
        start_load(32'd5, 1'b0, 1'b1, 1'b0);
        wait_done("after_rst5", 33, 0, 32'd0);
        check("after_rst5_seg", 64'(oSeg), 64'hFFFF_FFFF_FF92);

        // Randomized values over several magnitude ranges and both modes
        for (int t = 0; t < 24; t++) begin
            case ($urandom % 4)
                0: rv = $urandom % 1000;
                1: rv = $urandom % 2000000;
                2: rv = $urandom % 32'h0200_0000;
                default: rv = $urandom;
            endcase
            rh = 1'($urandom % 2);
            rb = 1'($urandom % 2);
            run_case($sformatf("rand%0d", t), rv, rh, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
